jt51_wrq: RTL

JT51_WRQ -- requirements
Module: jt51_wrq

---
 rtl/jt51_wrq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/jt51_wrq.sv
// jt51_wrq -- CPU write queue in front of the JT51 register-map stage.
//
// The CPU can write at any clk. The register-map stage only accepts a write
// when it is not busy, and it advances on the P1 clock enable (cen). This
// block buffers CPU writes in a 2**AW-entry FIFO and replays them one at a
// time, in order, through a small handshake FSM.
//
// Ports
//   clk, rst_n         system clock, synchronous active-low reset
//   cen                P1 clock enable; only the issue FSM uses it
//   cpu_wr/a0/din      CPU write strobe (one clk wide), address bit and data
//   cpu_full           queue holds 2**AW entries
//   level              current entry count (AW+1 bits)
//   ovf / ovf_clr      sticky "write dropped" flag and its clear
//   write/a0/d_in      write strobe, address bit and data to the register map
//   busy               busy flag from the register map
//
// Optional feature: define JT51_WRQ_ADDR_SKIP_EN to drop address writes
// (a0=0) that repeat the last issued address.
module jt51_wrq #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          cpu_wr,
  input  logic          cpu_a0,
  input  logic [7:0]    cpu_din,
  output logic          cpu_full,
  output logic [AW:0]   level,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic          write,
  output logic          a0,
  output logic [7:0]    d_in,
  input  logic          busy
);

  localparam int DEPTH = 2**AW;

  typedef struct packed {
    logic       a0;
    logic [7:0] d;
  } wrq_ent_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} st_t;

  wrq_ent_t      mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  st_t           st_q, st_d;
  logic          wd_q, wd_d;
  logic          write_q, write_d;
  logic          ovf_q;
  wrq_ent_t      out_q, out_d;
  logic          push, pop, full, empty, skip;
  wrq_ent_t      head;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  // A write that arrives while full is dropped even if a pop frees a slot in
  // the same clk: the CPU saw cpu_full high and must not rely on the race.
  assign push  = cpu_wr & ~full;
  assign head  = mem_q[rp_q];

`ifdef JT51_WRQ_ADDR_SKIP_EN
  logic [7:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;
  assign skip = ~head.a0 & last_vld_q & (head.d == last_q);
`else
  assign skip = 1'b0;
`endif

  // Issue FSM. The watchdog in WAIT_HI counts the ISSUE cycle as the first
  // busy-low cycle, so a stage that never raises busy sees strobes exactly
  // 3 cen apart.
  always_comb begin
    st_d    = st_q;
    wd_d    = wd_q;
    write_d = write_q;
    out_d   = out_q;
    pop     = 1'b0;
`ifdef JT51_WRQ_ADDR_SKIP_EN
    last_d     = last_q;
    last_vld_d = last_vld_q;
`endif
    if (cen) begin
      case (st_q)
        IDLE: begin
          if (!empty) begin
            if (skip) begin
              pop = 1'b1;              // redundant address write, no strobe
            end else if (!busy) begin
              pop     = 1'b1;
              write_d = 1'b1;
              out_d   = head;
              st_d    = ISSUE;
`ifdef JT51_WRQ_ADDR_SKIP_EN
              if (!head.a0) begin
                last_d     = head.d;
                last_vld_d = 1'b1;
              end
`endif
            end
          end
        end
        ISSUE: begin
          write_d = 1'b0;
          wd_d    = ~busy;
          st_d    = WAIT_HI;
        end
        WAIT_HI: begin
          if (busy)      st_d = WAIT_LO;
          else if (wd_q) st_d = IDLE;
          else           wd_d = 1'b1;
        end
        WAIT_LO: begin
          if (!busy) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      st_q    <= IDLE;
      wd_q    <= 1'b0;
      write_q <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef JT51_WRQ_ADDR_SKIP_EN
      last_q     <= 8'h00;
      last_vld_q <= 1'b0;
`endif
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      st_q    <= st_d;
      wd_q    <= wd_d;
      write_q <= write_d;
      out_q   <= out_d;
      if (cpu_wr && full) ovf_q <= 1'b1;   // drop beats a simultaneous clear
      else if (ovf_clr)   ovf_q <= 1'b0;
`ifdef JT51_WRQ_ADDR_SKIP_EN
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
`endif
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wp_q] <= '{a0: cpu_a0, d: cpu_din};
  end

  assign cpu_full = full;
  assign level    = cnt_q;
  assign ovf      = ovf_q;
  assign write    = write_q;
  assign a0       = out_q.a0;
  assign d_in     = out_q.d;

endmodule
